// File: rtl/alu_ctl_pkg.sv
// Shared ALU control encoding and sequencer state type for the MUL/DIV engine.
package alu_ctl_pkg;

  localparam int ALU_W = 8;

  // ci : carry-in
  // nb : invert operand b (after optional zeroing)
  // ic : inhibit operand b (b treated as zero)
  // na : invert operand a
  // xo : XOR result path
  // no : invert the final result
  // sr : shift operand a right by one
  // ss : with sr, arithmetic shift; without sr, AND result path
  typedef struct packed {
    logic ci;
    logic nb;
    logic ic;
    logic na;
    logic xo;
    logic no;
    logic sr;
    logic ss;
  } alu_ctl_t;

  //                                      ci nb ic na xo no sr ss
  localparam alu_ctl_t CTL_ADD = 8'b0000_0000;
  localparam alu_ctl_t CTL_SUB = 8'b1100_0000;  // a + ~b + 1
  localparam alu_ctl_t CTL_SHR = 8'b0000_0010;
  localparam alu_ctl_t CTL_SAR = 8'b0000_0011;
  localparam alu_ctl_t CTL_INC = 8'b1010_0000;  // a + 0 + 1
  localparam alu_ctl_t CTL_DEC = 8'b0110_0000;  // a + 8'hFF
  localparam alu_ctl_t CTL_NOT = 8'b0011_0000;  // ~a + 0
  localparam alu_ctl_t CTL_NEG = 8'b1011_0000;  // ~a + 1
  localparam alu_ctl_t CTL_AND = 8'b0000_0001;
  localparam alu_ctl_t CTL_OR  = 8'b0101_0101;  // ~(~a & ~b)
  localparam alu_ctl_t CTL_XOR = 8'b0000_1000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STEP_A = 2'd1,
    STEP_B = 2'd2,
    FIN    = 2'd3
  } seq_state_t;

endpackage

// File: rtl/alu_muldiv_seq_alu.sv
// 8-bit combinational ALU steered by alu_ctl_t control lines.
module alu_muldiv_seq_alu
  import alu_ctl_pkg::*;
(
  input  logic [ALU_W-1:0] a,
  input  logic [ALU_W-1:0] b,
  input  alu_ctl_t         ctl,
  output logic [ALU_W-1:0] out,
  output logic             cf,
  output logic             zf,
  output logic             sf
);

  logic [ALU_W-1:0] opa;
  logic [ALU_W-1:0] opb_raw;
  logic [ALU_W-1:0] opb;
  logic [ALU_W:0]   sum;
  logic [ALU_W-1:0] raw;

  // Operand conditioning, then one of add / shift / xor / and, then optional output inversion.
  always_comb begin
    opa     = ctl.na ? ~a : a;
    opb_raw = ctl.ic ? '0 : b;
    opb     = ctl.nb ? ~opb_raw : opb_raw;
    sum     = {1'b0, opa} + {1'b0, opb} + {{ALU_W{1'b0}}, ctl.ci};
    raw     = sum[ALU_W-1:0];
    cf      = sum[ALU_W];
    if (ctl.sr) begin
      raw = {(ctl.ss ? opa[ALU_W-1] : 1'b0), opa[ALU_W-1:1]};
      cf  = opa[0];
    end else if (ctl.xo) begin
      raw = opa ^ opb;
      cf  = 1'b0;
    end else if (ctl.ss) begin
      raw = opa & opb;
      cf  = 1'b0;
    end
    out = ctl.no ? ~raw : raw;
    zf  = (out == '0);
    sf  = out[ALU_W-1];
  end

endmodule

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle unsigned 8x8 multiply / 8/8 divide sequencer around one shared ALU.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | waiting for start; results held
//   STEP_A | mul: conditional add of multiplier; div: shift remainder left
//   STEP_B | mul: shift product right; div: trial subtract / restore
//   FIN    | done pulse, results valid; back to IDLE next cycle
module alu_muldiv_seq
  import alu_ctl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo,
  output logic             div_zero
);

  if (WIDTH != ALU_W) begin : g_width_check
    $error("alu_muldiv_seq: WIDTH must equal the ALU width of 8");
  end

  seq_state_t       state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic             c_q, c_d;
  logic [2:0]       cnt_q, cnt_d;
  logic             op_q, op_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] res_hi_q, res_hi_d;
  logic [WIDTH-1:0] res_lo_q, res_lo_d;
  logic             div_zero_q, div_zero_d;

  logic [ALU_W-1:0] alu_a;
  logic [ALU_W-1:0] alu_b;
  alu_ctl_t         alu_ctl;
  logic [ALU_W-1:0] alu_out;
  logic             alu_cf;
  logic             alu_zf;
  logic             alu_sf;
  logic             unused_flags;

  assign unused_flags = alu_zf ^ alu_sf;

  alu_muldiv_seq_alu u_alu (
    .a   (alu_a),
    .b   (alu_b),
    .ctl (alu_ctl),
    .out (alu_out),
    .cf  (alu_cf),
    .zf  (alu_zf),
    .sf  (alu_sf)
  );

  // Next-state, datapath and ALU steering for every state.
  always_comb begin
    state_d    = state_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    m_d        = m_q;
    c_d        = c_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    res_hi_d   = res_hi_q;
    res_lo_d   = res_lo_q;
    div_zero_d = div_zero_q;
    alu_a      = '0;
    alu_b      = '0;
    alu_ctl    = CTL_ADD;

    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          hi_d       = '0;
          lo_d       = a;
          m_d        = b;
          c_d        = 1'b0;
          cnt_d      = '0;
          op_d       = op;
          div_zero_d = 1'b0;
          busy_d     = 1'b1;
          state_d    = STEP_A;
          // Divide by zero skips the iterations; results are loaded as FIN is entered.
          if (op && (b == '0)) begin
            hi_d       = a;
            lo_d       = '1;
            div_zero_d = 1'b1;
            done_d     = 1'b1;
            res_hi_d   = a;
            res_lo_d   = '1;
            state_d    = FIN;
          end
        end
      end

      STEP_A: begin
        alu_a = hi_q;
        if (!op_q) begin
          alu_b = m_q;
          if (lo_q[0]) begin
            hi_d = alu_out;
            c_d  = alu_cf;
          end else begin
            c_d  = 1'b0;
          end
        end else begin
          // hi + hi + lo[7] shifts the {hi,lo} pair left; bit 8 lands in c.
          alu_b      = hi_q;
          alu_ctl.ci = lo_q[WIDTH-1];
          hi_d       = alu_out;
          c_d        = alu_cf;
          lo_d       = {lo_q[WIDTH-2:0], 1'b0};
        end
        state_d = STEP_B;
      end

      STEP_B: begin
        alu_a = hi_q;
        if (!op_q) begin
          alu_ctl = CTL_SHR;
          hi_d    = {c_q, alu_out[WIDTH-2:0]};
          lo_d    = {hi_q[0], lo_q[WIDTH-1:1]};
        end else begin
          // A set c means the 9-bit partial remainder already exceeds any divisor.
          alu_b   = m_q;
          alu_ctl = CTL_SUB;
          if (c_q || alu_cf) begin
            hi_d = alu_out;
            lo_d = {lo_q[WIDTH-1:1], 1'b1};
          end
        end
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          done_d   = 1'b1;
          res_hi_d = hi_d;
          res_lo_d = lo_d;
          state_d  = FIN;
        end else begin
          state_d  = STEP_A;
        end
      end

      FIN: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // All sequencer state and registered outputs; synchronous reset aborts any operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      hi_q       <= '0;
      lo_q       <= '0;
      m_q        <= '0;
      c_q        <= 1'b0;
      cnt_q      <= '0;
      op_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      res_hi_q   <= '0;
      res_lo_q   <= '0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      m_q        <= m_d;
      c_q        <= c_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      res_hi_q   <= res_hi_d;
      res_lo_q   <= res_lo_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign res_hi   = res_hi_q;
  assign res_lo   = res_lo_q;
  assign div_zero = div_zero_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Scoreboard bench for alu_muldiv_seq: expectations queued at issue, popped at done.
module tb_alu_muldiv_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       op;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] res_hi;
  logic [7:0] res_lo;
  logic       div_zero;

  typedef struct {
    logic [7:0] hi;
    logic [7:0] lo;
    logic       dz;
    int         lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  alu_muldiv_seq #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .res_hi   (res_hi),
    .res_lo   (res_lo),
    .div_zero (div_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one request for a cycle and queue its reference result; returns in cycle 1 after accept.
  task automatic issue(input logic o, input logic [7:0] x, input logic [7:0] y);
    exp_t        e;
    logic [15:0] prod;
    start = 1'b1; op = o; a = x; b = y;
    if (o && y == 8'd0) begin
      e = '{hi: x, lo: 8'hFF, dz: 1'b1, lat: 1};
    end else if (o) begin
      e = '{hi: x % y, lo: x / y, dz: 1'b0, lat: 17};
    end else begin
      prod = 16'(x) * 16'(y);
      e = '{hi: prod[15:8], lo: prod[7:0], dz: 1'b0, lat: 17};
    end
    sb.push_back(e);
    step();
    start = 1'b0;
    op = 1'($urandom);
    a  = 8'($urandom);
    b  = 8'($urandom);
  endtask

  // Bounded wait for done; lat is the cycle index after accept where done was seen (40 = timeout).
  task automatic wait_done(input int lat0, output int lat, output int busy_n);
    lat    = lat0;
    busy_n = 0;
    while (1) begin
      if (busy === 1'b1) busy_n++;
      if (done === 1'b1 || lat >= 40) break;
      step();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; op = 1'b0; a = 8'd0; b = 8'd0;
    repeat (3) step();
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (res_hi !== 8'd0) begin errors++; $display("FAIL reset_res_hi got %h want 00", res_hi); end
    checks++; if (res_lo !== 8'd0) begin errors++; $display("FAIL reset_res_lo got %h want 00", res_lo); end
    checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL reset_div_zero got %b want 0", div_zero); end
  endtask

  task automatic test_mul();
    logic [7:0] xa[3] = '{8'd13, 8'd255, 8'd0};
    logic [7:0] xb[3] = '{8'd11, 8'd255, 8'd200};
    int   lat, bn;
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      issue(1'b0, xa[i], xb[i]);
      wait_done(1, lat, bn);
      e = sb.pop_front();
      checks++; if (lat !== e.lat) begin errors++; $display("FAIL mul_latency[%0d] got %0d want %0d", i, lat, e.lat); end
      checks++; if (bn !== e.lat) begin errors++; $display("FAIL mul_busy_cycles[%0d] got %0d want %0d", i, bn, e.lat); end
      checks++; if ({res_hi, res_lo} !== {e.hi, e.lo}) begin
        errors++; $display("FAIL mul_result[%0d] got %h want %h", i, {res_hi, res_lo}, {e.hi, e.lo});
      end
      checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL mul_div_zero[%0d] got %b want 0", i, div_zero); end
      step();
      checks++; if (done !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL mul_done_pulse[%0d] got done=%b busy=%b want 0 0", i, done, busy);
      end
    end
  endtask

  task automatic test_div();
    logic [7:0] xa[3] = '{8'd200, 8'd9, 8'd255};
    logic [7:0] xb[3] = '{8'd7, 8'd10, 8'd1};
    int   lat, bn;
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      issue(1'b1, xa[i], xb[i]);
      wait_done(1, lat, bn);
      e = sb.pop_front();
      checks++; if (lat !== e.lat) begin errors++; $display("FAIL div_latency[%0d] got %0d want %0d", i, lat, e.lat); end
      checks++; if (res_lo !== e.lo) begin errors++; $display("FAIL div_quotient[%0d] got %0d want %0d", i, res_lo, e.lo); end
      checks++; if (res_hi !== e.hi) begin errors++; $display("FAIL div_remainder[%0d] got %0d want %0d", i, res_hi, e.hi); end
      checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL div_div_zero[%0d] got %b want 0", i, div_zero); end
      step();
    end
  endtask

  task automatic test_div_zero();
    int   lat, bn;
    exp_t e;
    issue(1'b1, 8'd5, 8'd0);
    wait_done(1, lat, bn);
    e = sb.pop_front();
    checks++; if (lat !== e.lat) begin errors++; $display("FAIL dz_latency got %0d want %0d", lat, e.lat); end
    checks++; if (bn !== 1) begin errors++; $display("FAIL dz_busy_cycles got %0d want 1", bn); end
    checks++; if (div_zero !== 1'b1) begin errors++; $display("FAIL dz_flag got %b want 1", div_zero); end
    checks++; if ({res_hi, res_lo} !== {e.hi, e.lo}) begin
      errors++; $display("FAIL dz_result got %h want %h", {res_hi, res_lo}, {e.hi, e.lo});
    end
    step();
    issue(1'b0, 8'd2, 8'd3);
    checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL dz_clear_at_accept got %b want 0", div_zero); end
    checks++; if ({res_hi, res_lo} !== 16'h05FF) begin
      errors++; $display("FAIL dz_result_held got %h want 05ff", {res_hi, res_lo});
    end
    wait_done(1, lat, bn);
    e = sb.pop_front();
    checks++; if ({res_hi, res_lo} !== {e.hi, e.lo} || lat !== e.lat) begin
      errors++; $display("FAIL dz_next_mul got %h lat %0d want %h lat %0d", {res_hi, res_lo}, lat, {e.hi, e.lo}, e.lat);
    end
    step();
  endtask

  task automatic test_start_ignored();
    int   lat, bn;
    exp_t e;
    issue(1'b0, 8'd13, 8'd11);
    repeat (4) step();
    start = 1'b1; op = 1'b0; a = 8'd1; b = 8'd1;
    step();
    start = 1'b0;
    wait_done(6, lat, bn);
    e = sb.pop_front();
    checks++; if (lat !== e.lat) begin errors++; $display("FAIL ign_latency got %0d want %0d", lat, e.lat); end
    checks++; if ({res_hi, res_lo} !== {e.hi, e.lo}) begin
      errors++; $display("FAIL ign_result got %h want %h", {res_hi, res_lo}, {e.hi, e.lo});
    end
    step();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL ign_done_single got %b want 0", done); end
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_no_queue got busy=%b want 0", busy); end
  endtask

  task automatic test_reset_mid_op();
    int   lat, bn, pulses;
    exp_t e;
    issue(1'b1, 8'd200, 8'd7);
    repeat (7) step();
    rst = 1'b1; start = 1'b1; op = 1'b0; a = 8'd3; b = 8'd4;
    step();
    rst = 1'b0; start = 1'b0;
    void'(sb.pop_front());
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", busy); end
    checks++; if ({res_hi, res_lo, div_zero} !== 17'd0) begin
      errors++; $display("FAIL rstmid_results got %h %h %b want 00 00 0", res_hi, res_lo, div_zero);
    end
    pulses = 0;
    for (int i = 0; i < 25; i++) begin
      if (done !== 1'b0) pulses++;
      step();
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL rstmid_no_done got %0d pulses want 0", pulses); end
    issue(1'b0, 8'd3, 8'd4);
    wait_done(1, lat, bn);
    e = sb.pop_front();
    checks++; if ({res_hi, res_lo} !== {e.hi, e.lo} || lat !== e.lat) begin
      errors++; $display("FAIL rstmid_next_mul got %h lat %0d want %h lat %0d", {res_hi, res_lo}, lat, {e.hi, e.lo}, e.lat);
    end
    step();
  endtask

  task automatic test_back_to_back();
    int         lat, bn;
    exp_t       e;
    logic       o;
    logic [7:0] x, y;
    for (int i = 0; i < 8; i++) begin
      o = 1'($urandom_range(0, 1));
      x = 8'($urandom);
      y = (i == 5) ? 8'd0 : 8'($urandom);
      issue(o, x, y);
      wait_done(1, lat, bn);
      e = sb.pop_front();
      checks++; if ({res_hi, res_lo, div_zero} !== {e.hi, e.lo, e.dz} || lat !== e.lat) begin
        errors++;
        $display("FAIL b2b[%0d] op=%0d a=%0d b=%0d got %h %h %b lat %0d want %h %h %b lat %0d",
                 i, o, x, y, res_hi, res_lo, div_zero, lat, e.hi, e.lo, e.dz, e.lat);
      end
      step();
    end
    checks++; if (sb.size() !== 0) begin errors++; $display("FAIL scoreboard_drain got %0d left want 0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_div_zero();
    test_start_ignored();
    test_reset_mid_op();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
